piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parametrised parallel-in/serial-out shift register with a ready/valid load handshake, a shift-enable input and frame status outputs.
- Converts a WIDTH-bit word into a serial bitstream.
- Bit order is selectable by parameter.
- Supports zero-bubble back-to-back frames. It sits between a parallel data source and a serial line driver or bit-clock-gated link.

Parameters:
- WIDTH, 8, data word width in bits. Minimum 2.
- LSB_FIRST, 1, 1 = bit 0 shifted out first; 0 = bit WIDTH-1 shifted out first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- load_valid  input  1  source has a word on load_data.
- load_ready  output  1  block can accept a word this cycle.
- load_data  input  WIDTH  parallel word. Captured when load_valid && load_ready.
- shift_en  input  1  consumer takes the current sout bit this cycle.
- sout  output  1  current serial bit.
- sout_valid  output  1  sout carries a frame bit.
- busy  output  1  frame in progress (state SHIFT).
- done  output  1  one-cycle pulse the cycle after the last frame bit is consumed.

Behaviour:
- Reset: the one clock is clk; reset rst is synchronous and active-high. On a clk edge with rst=1:
  - state=IDLE, shift register=0, bit counter=0, done=0.
  - sout=0, sout_valid=0, busy=0.
  - load_ready is forced 0 while rst=1.
  - Reset mid-frame aborts the frame with no done pulse.
- States are IDLE and SHIFT.
- Bit counter:
  - Width is $clog2(WIDTH+1).
  - Counts bits consumed in the current frame.
  - FRAME_LEN = WIDTH, or WIDTH+1 with the optional feature.
  - last = (cnt == FRAME_LEN-1).
- load_ready (combinational) = !rst && (state==IDLE || (state==SHIFT && last && shift_en)).
- IDLE:
  - sout=0, sout_valid=0, busy=0.
  - On load_valid && load_ready: capture load_data, set cnt=0, move to SHIFT.
  - The first bit appears on sout the next cycle (load-to-first-bit latency 1 cycle).
- SHIFT:
  - sout_valid=1, busy=1.
  - sout = shreg[0] if LSB_FIRST=1, else shreg[WIDTH-1].
  - shift_en=0: shreg and cnt hold, and sout is stable.
  - shift_en=1 and not last: shift by one toward the output end (zero fill), cnt+1.
  - shift_en=1 and last: done=1 next cycle. Then either:
    - load_valid=1: the new word is captured, cnt=0, stay in SHIFT. The new frame's first bit is on sout the next cycle, with no idle gap.
    - load_valid=0: go to IDLE.
- load_valid while load_ready=0 is ignored. load_data is not captured and no error is flagged. The source must hold load_valid until it sees ready.
- shift_en in IDLE is ignored.
- done is registered and lasts exactly 1 cycle per completed frame. It can coincide with sout_valid=1 of the next frame.

Optional Feature:
- Macro PISO_PARITY_EN.
- Defined:
  - Each word is captured together with its even-parity bit (XOR of load_data).
  - FRAME_LEN=WIDTH+1. The parity bit is sent after the last data bit, regardless of LSB_FIRST.
  - Counter, last and done are based on WIDTH+1.
- Undefined:
  - FRAME_LEN=WIDTH.
  - No parity storage or logic is present.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with load_valid=1 -> load_ready=0, sout_valid=0, busy=0, done=0. The first cycle after rst=0 gives load_ready=1.
2. WIDTH=8, LSB_FIRST=1: load 8'h1E, then shift_en=1 continuously -> sout = 0,1,1,1,1,0,0,0 on 8 consecutive cycles. done pulses the cycle after the 8th bit, then IDLE.
3. LSB_FIRST=0: load 8'h1E -> sout = 0,0,0,1,1,1,1,0. Second load attempt mid-frame with 8'hFF is ignored (load_ready=0) and the frame is unchanged.
4. Back-to-back: load_valid held with 8'h01 then 8'h80, shift_en=1 -> 16 contiguous valid bits (LSB first: 1, seven 0s, seven 0s, 1). done is high at cycles 9 and 17 after the first load, and sout_valid never drops between frames.
5. Stall: load 8'hA5, and set shift_en=0 for 5 cycles after bit 3 -> sout holds bit 3's value (0) for those cycles. The total sequence is still 1,0,1,0,0,1,0,1 and done appears only after the 8th accepted bit.
6. PISO_PARITY_EN defined: load 8'h07 -> sout = 1,1,1,0,0,0,0,0,1 (parity=1), and done is high after the 9th bit. Reset asserted at bit 4 -> IDLE next cycle with no done.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with ready/valid load and shift-enable handshake.
// Define PISO_PARITY_EN to append an even-parity bit after each word's data bits.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             take;
    logic             fire;
    logic             data_bit;

    assign last       = (cnt == CW'(FRAME_LEN - 1));
    assign take       = (state == SHIFT) && shift_en;
    assign load_ready = !rst && ((state == IDLE) || (take && last));
    assign fire       = load_valid && load_ready;
    assign data_bit   = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];

`ifdef PISO_PARITY_EN
    logic par;

    // Data bits are zero-filled away, so only the parity slot needs a mux.
    assign sout = busy & ((cnt == CW'(WIDTH)) ? par : data_bit);

    always_ff @(posedge clk) begin
        if (rst) begin
            par <= 1'b0;
        end else if (fire) begin
            par <= ^load_data;
        end
    end
`else
    assign sout = busy & data_bit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            sout_valid <= 1'b0;
        end else begin
            done <= take && last;
            if (fire) begin
                state      <= SHIFT;
                shreg      <= load_data;
                cnt        <= '0;
                busy       <= 1'b1;
                sout_valid <= 1'b1;
            end else if (take) begin
                if (LSB_FIRST) begin
                    shreg <= {1'b0, shreg[WIDTH-1:1]};
                end else begin
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                end
                if (last) begin
                    state      <= IDLE;
                    cnt        <= '0;
                    busy       <= 1'b0;
                    sout_valid <= 1'b0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: LSB-first and MSB-first instances in lockstep, scoreboard monitor plus per-scenario tasks.
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_valid = 1'b0;
    logic [W-1:0] load_data = '0;
    logic         shift_en = 1'b0;

    logic load_ready, sout, sout_valid, busy, done;
    logic load_ready_m, sout_m, sout_valid_m, busy_m, done_m;

    int ntotal = 0;
    int npass  = 0;

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .shift_en(shift_en), .sout(sout),
        .sout_valid(sout_valid), .busy(busy), .done(done)
    );

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready_m),
        .load_data(load_data), .shift_en(shift_en), .sout(sout_m),
        .sout_valid(sout_valid_m), .busy(busy_m), .done(done_m)
    );

    always #5 clk = ~clk;

    // Expected transmit order of one frame: element i is the i-th bit on the line.
    function automatic logic [FL-1:0] frame_bits(input logic [W-1:0] w, input bit lsb);
        logic [FL-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) r[i] = lsb ? w[i] : w[W-1-i];
`ifdef PISO_PARITY_EN
        r[W] = ^w;
`endif
        return r;
    endfunction

    // Scoreboard monitor: model of the handshake and frame progress.
    logic     q_l[$];
    logic     q_m[$];
    bit       m_busy = 1'b0;
    bit       m_done = 1'b0;
    int       m_rem  = 0;
    logic     rdy_exp;
    logic [FL-1:0] fb_l, fb_m;

    always @(negedge clk) begin
        rdy_exp = !rst && (!m_busy || (m_rem == 1 && shift_en));
        ntotal++;
        if (load_ready !== rdy_exp) $display("FAIL sb_ready: got %b exp %b t=%0t", load_ready, rdy_exp, $time);
        else npass++;
        ntotal++;
        if (load_ready_m !== rdy_exp) $display("FAIL sb_ready_m: got %b exp %b t=%0t", load_ready_m, rdy_exp, $time);
        else npass++;
        ntotal++;
        if (busy !== m_busy || sout_valid !== m_busy || busy_m !== m_busy || sout_valid_m !== m_busy)
            $display("FAIL sb_busy: got %b%b%b%b exp %b t=%0t", busy, sout_valid, busy_m, sout_valid_m, m_busy, $time);
        else npass++;
        ntotal++;
        if (done !== m_done || done_m !== m_done)
            $display("FAIL sb_done: got %b/%b exp %b t=%0t", done, done_m, m_done, $time);
        else npass++;
        if (m_busy) begin
            ntotal++;
            if (q_l.size() == 0 || q_m.size() == 0) $display("FAIL sb_queue: got empty exp bits t=%0t", $time);
            else if (sout !== q_l[0] || sout_m !== q_m[0])
                $display("FAIL sb_sout: got %b/%b exp %b/%b t=%0t", sout, sout_m, q_l[0], q_m[0], $time);
            else npass++;
        end else begin
            ntotal++;
            if (sout !== 1'b0 || sout_m !== 1'b0) $display("FAIL sb_idle_sout: got %b/%b exp 0 t=%0t", sout, sout_m, $time);
            else npass++;
        end
        m_done = 1'b0;
        if (rst) begin
            q_l.delete();
            q_m.delete();
            m_busy = 1'b0;
            m_rem  = 0;
        end else begin
            if (m_busy && shift_en) begin
                if (q_l.size() > 0) void'(q_l.pop_front());
                if (q_m.size() > 0) void'(q_m.pop_front());
                m_rem--;
                if (m_rem == 0) begin
                    m_done = 1'b1;
                    m_busy = 1'b0;
                end
            end
            if (load_valid && rdy_exp) begin
                fb_l = frame_bits(load_data, 1'b1);
                fb_m = frame_bits(load_data, 1'b0);
                for (int i = 0; i < FL; i++) begin
                    q_l.push_back(fb_l[i]);
                    q_m.push_back(fb_m[i]);
                end
                m_rem  = FL;
                m_busy = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load_valid = 1'b1; load_data = 8'h55; shift_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ntotal++;
            if (load_ready !== 1'b0 || sout_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
                $display("FAIL reset_outputs: got rdy=%b sv=%b busy=%b done=%b exp all 0", load_ready, sout_valid, busy, done);
            else npass++;
            tick();
        end
        rst = 1'b0; load_valid = 1'b0; shift_en = 1'b1;
        @(negedge clk);
        ntotal++;
        if (load_ready !== 1'b1) $display("FAIL reset_release_ready: got %b exp 1", load_ready);
        else npass++;
        tick();
        @(negedge clk);
        ntotal++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL idle_shift_en: got busy=%b done=%b exp 0/0", busy, done);
        else npass++;
        tick();
        shift_en = 1'b0;
    endtask

    task automatic test_lsb_first();
        logic [FL-1:0] e;
        e = frame_bits(8'h1E, 1'b1);
        load_valid = 1'b1; load_data = 8'h1E; shift_en = 1'b1;
        @(negedge clk);
        ntotal++;
        if (load_ready !== 1'b1) $display("FAIL lsb_load_ready: got %b exp 1", load_ready);
        else npass++;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            ntotal++;
            if (sout !== e[i] || sout_valid !== 1'b1) $display("FAIL lsb_bit%0d: got %b (sv %b) exp %b", i, sout, sout_valid, e[i]);
            else npass++;
            tick();
        end
        @(negedge clk);
        ntotal++;
        if (done !== 1'b1 || busy !== 1'b0) $display("FAIL lsb_done: got done=%b busy=%b exp 1/0", done, busy);
        else npass++;
        tick();
        shift_en = 1'b0;
    endtask

    task automatic test_msb_first();
        logic [FL-1:0] e;
        e = frame_bits(8'h1E, 1'b0);
        load_valid = 1'b1; load_data = 8'h1E; shift_en = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            if (i == 3) begin load_valid = 1'b1; load_data = 8'hFF; end
            if (i == 5) load_valid = 1'b0;
            @(negedge clk);
            if (i == 3 || i == 4) begin
                ntotal++;
                if (load_ready_m !== 1'b0) $display("FAIL msb_midframe_ready: got %b exp 0", load_ready_m);
                else npass++;
            end
            ntotal++;
            if (sout_m !== e[i]) $display("FAIL msb_bit%0d: got %b exp %b", i, sout_m, e[i]);
            else npass++;
            tick();
        end
        @(negedge clk);
        ntotal++;
        if (done_m !== 1'b1 || busy_m !== 1'b0) $display("FAIL msb_done: got done=%b busy=%b exp 1/0", done_m, busy_m);
        else npass++;
        tick();
        shift_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [FL-1:0] e1, e2;
        logic          eb, ed;
        e1 = frame_bits(8'h01, 1'b1);
        e2 = frame_bits(8'h80, 1'b1);
        load_valid = 1'b1; load_data = 8'h01; shift_en = 1'b1;
        for (int k = 0; k <= 2*FL + 1; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= 2*FL) begin
                eb = (k <= FL) ? e1[k-1] : e2[k-FL-1];
                ntotal++;
                if (sout_valid !== 1'b1 || sout !== eb) $display("FAIL b2b_bit k=%0d: got sv=%b sout=%b exp sv=1 sout=%b", k, sout_valid, sout, eb);
                else npass++;
            end
            ed = (k == FL + 1) || (k == 2*FL + 1);
            ntotal++;
            if (done !== ed) $display("FAIL b2b_done k=%0d: got %b exp %b", k, done, ed);
            else npass++;
            tick();
            if (k == 0) load_data = 8'h80;
            if (k == FL) load_valid = 1'b0;
        end
        shift_en = 1'b0;
    endtask

    task automatic test_stall();
        logic [FL-1:0] e;
        int acc;
        int stall;
        e = frame_bits(8'hA5, 1'b1);
        acc = 0; stall = 0;
        load_valid = 1'b1; load_data = 8'hA5; shift_en = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int c = 0; c < 40 && acc < FL; c++) begin
            shift_en = !(acc == 3 && stall < 5);
            @(negedge clk);
            ntotal++;
            if (done !== 1'b0) $display("FAIL stall_early_done: got %b exp 0 (acc %0d)", done, acc);
            else npass++;
            ntotal++;
            if (sout !== e[acc]) $display("FAIL stall_bit%0d: got %b exp %b (stall %0d)", acc, sout, e[acc], stall);
            else npass++;
            if (shift_en) acc++;
            else stall++;
            tick();
        end
        ntotal++;
        if (acc != FL || stall != 5) $display("FAIL stall_progress: got acc=%0d stall=%0d exp %0d/5", acc, stall, FL);
        else npass++;
        @(negedge clk);
        ntotal++;
        if (done !== 1'b1) $display("FAIL stall_done: got %b exp 1", done);
        else npass++;
        tick();
        shift_en = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        load_valid = 1'b1; load_data = 8'h07; shift_en = 1'b1;
        tick();
        load_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        @(negedge clk);
        ntotal++;
        if (busy !== 1'b1 || load_ready !== 1'b0) $display("FAIL abort_pre: got busy=%b rdy=%b exp 1/0", busy, load_ready);
        else npass++;
        tick();
        rst = 1'b0;
        @(negedge clk);
        ntotal++;
        if (busy !== 1'b0 || sout_valid !== 1'b0 || done !== 1'b0 || sout !== 1'b0)
            $display("FAIL abort_idle: got busy=%b sv=%b done=%b sout=%b exp 0000", busy, sout_valid, done, sout);
        else npass++;
        tick();
        @(negedge clk);
        ntotal++;
        if (done !== 1'b0) $display("FAIL abort_no_done: got %b exp 0", done);
        else npass++;
        tick();
        shift_en = 1'b0;
    endtask

`ifdef PISO_PARITY_EN
    task automatic test_parity();
        logic [8:0] e;
        e = 9'b1_0000_0111;
        load_valid = 1'b1; load_data = 8'h07; shift_en = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            ntotal++;
            if (sout !== e[i] || done !== 1'b0) $display("FAIL parity_bit%0d: got %b done=%b exp %b done=0", i, sout, done, e[i]);
            else npass++;
            tick();
        end
        @(negedge clk);
        ntotal++;
        if (done !== 1'b1) $display("FAIL parity_done: got %b exp 1", done);
        else npass++;
        tick();
        shift_en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_back_to_back();
        test_stall();
`ifdef PISO_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        repeat (2) tick();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
